// File: rtl/crypto_cmd_sequencer.sv
// Command sequencer for a shared DES3 / PRESENT / HIGHT engine: accepts one
// block command, runs the selected core for its fixed or handshaked duration, returns the result.
module crypto_cmd_sequencer #(
    parameter int DES_CYCLES     = 18,
    parameter int PRESENT_CYCLES = 34,
    parameter int HIGHT_TIMEOUT  = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [1:0]   in_alg_i,
    input  logic         in_decrypt_i,
    input  logic [63:0]  in_data_i,
    input  logic [167:0] in_key_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [63:0]  out_data_o,
    output logic         out_err_o,
    output logic [63:0]  eng_input_o,
    output logic [167:0] eng_key_o,
    output logic [1:0]   eng_sel_o,
    output logic [5:0]   eng_round_sel_o,
    output logic         eng_decrypt_o,
    output logic         eng_key_load_o,
    output logic         eng_data_load_o,
    output logic         eng_op_o,
    output logic         eng_post_rdy_o,
    input  logic [63:0]  eng_output_i,
    input  logic         eng_ready_i
);

    localparam int CNT_W = 16;
    localparam logic [CNT_W-1:0] DES_LAST     = CNT_W'(DES_CYCLES - 1);
    localparam logic [CNT_W-1:0] PRESENT_LAST = CNT_W'(PRESENT_CYCLES - 1);
    localparam logic [CNT_W-1:0] HIGHT_LAST   = CNT_W'(HIGHT_TIMEOUT - 1);
    localparam logic [1:0] ALG_DES     = 2'd0;
    localparam logic [1:0] ALG_HIGHT   = 2'd2;
    localparam logic [1:0] ALG_ILLEGAL = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_RUN  = 3'd2,
        S_WAIT = 3'd3,
        S_CAPT = 3'd4,
        S_OUT  = 3'd5
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   run_last_s;
    logic               hs_s;
    logic [1:0]         alg_q;
    logic               decrypt_q;
    logic [63:0]        data_q;
    logic [167:0]       key_q;
    logic [63:0]        out_data_q, out_data_d;
    logic               out_err_q, out_err_d;
    logic               out_valid_q, out_valid_d;
    logic               load_q, load_d;
    logic               op_q, op_d;
    logic [5:0]         round_q, round_d;

    // in_ready must drop the instant reset asserts and rise in the first cycle after release,
    // so it is a decode of the state register gated by reset rather than a register of its own.
    assign in_ready_o = (state_q == S_IDLE) && !reset;
    assign hs_s       = in_valid_i && in_ready_o;
    assign run_last_s = (alg_q == ALG_DES) ? DES_LAST : PRESENT_LAST;

    // Next-state, counter and result-register logic.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        out_data_d = out_data_q;
        out_err_d  = out_err_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid_i) begin
                    if (in_alg_i == ALG_ILLEGAL) begin
                        state_d    = S_OUT;
                        out_data_d = 64'd0;
                        out_err_d  = 1'b1;
                    end else begin
                        state_d = S_LOAD;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LOAD: begin
                cnt_d   = {CNT_W{1'b0}};
                state_d = (alg_q == ALG_HIGHT) ? S_WAIT : S_RUN;
            end
            S_RUN: begin
                if (cnt_q == run_last_s) begin
                    state_d = S_CAPT;
                    cnt_d   = {CNT_W{1'b0}};
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_WAIT: begin
                // A ready arriving on the final timeout cycle still counts as success.
                if (eng_ready_i) begin
                    state_d = S_CAPT;
                    cnt_d   = {CNT_W{1'b0}};
                end else if (cnt_q == HIGHT_LAST) begin
                    state_d    = S_OUT;
                    cnt_d      = {CNT_W{1'b0}};
                    out_data_d = 64'd0;
                    out_err_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_CAPT: begin
                state_d    = S_OUT;
                out_data_d = eng_output_i;
                out_err_d  = 1'b0;
            end
            S_OUT: begin
                if (out_ready_i) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_OUT;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = {CNT_W{1'b0}};
            end
        endcase

        out_valid_d = (state_d == S_OUT);
        load_d      = (state_d == S_LOAD);
        op_d        = (state_d == S_WAIT);
        if ((state_d == S_RUN) && (alg_q == ALG_DES)) begin
            round_d = (cnt_d > 16'd15) ? 6'd15 : cnt_d[5:0];
        end else begin
            round_d = 6'd0;
        end
    end

    // State, counter and registered engine/result outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= {CNT_W{1'b0}};
            out_data_q  <= 64'd0;
            out_err_q   <= 1'b0;
            out_valid_q <= 1'b0;
            load_q      <= 1'b0;
            op_q        <= 1'b0;
            round_q     <= 6'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            out_data_q  <= out_data_d;
            out_err_q   <= out_err_d;
            out_valid_q <= out_valid_d;
            load_q      <= load_d;
            op_q        <= op_d;
            round_q     <= round_d;
        end
    end

    // Command holding registers, loaded only on an accepted command.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            alg_q     <= 2'd0;
            decrypt_q <= 1'b0;
            data_q    <= 64'd0;
            key_q     <= 168'd0;
        end else if (hs_s) begin
            alg_q     <= in_alg_i;
            decrypt_q <= in_decrypt_i;
            data_q    <= in_data_i;
            key_q     <= in_key_i;
        end else begin
            alg_q     <= alg_q;
            decrypt_q <= decrypt_q;
            data_q    <= data_q;
            key_q     <= key_q;
        end
    end

    assign out_valid_o     = out_valid_q;
    assign out_data_o      = out_data_q;
    assign out_err_o       = out_err_q;
    assign eng_input_o     = data_q;
    assign eng_key_o       = key_q;
    assign eng_sel_o       = alg_q;
    assign eng_decrypt_o   = decrypt_q;
    assign eng_round_sel_o = round_q;
    assign eng_key_load_o  = load_q;
    assign eng_data_load_o = load_q;
    assign eng_op_o        = op_q;
    assign eng_post_rdy_o  = op_q;

endmodule

// File: tb/tb_crypto_cmd_sequencer.sv
// Self-checking bench for crypto_cmd_sequencer: directed scenarios plus random
// commands, each checked cycle by cycle against a latency/timing model of the command protocol.
module tb_crypto_cmd_sequencer;

    localparam int DES_N     = 18;
    localparam int PRESENT_N = 34;
    localparam int HIGHT_TO  = 64;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid_s, in_ready_s, in_decrypt_s;
    logic [1:0]   in_alg_s;
    logic [63:0]  in_data_s;
    logic [167:0] in_key_s;
    logic         out_valid_s, out_ready_s, out_err_s;
    logic [63:0]  out_data_s;
    logic [63:0]  eng_input_s, eng_output_s;
    logic [167:0] eng_key_s;
    logic [1:0]   eng_sel_s;
    logic [5:0]   eng_round_sel_s;
    logic         eng_decrypt_s, eng_key_load_s, eng_data_load_s, eng_op_s, eng_post_rdy_s;
    logic         eng_ready_s;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    crypto_cmd_sequencer dut (
        .clk            (clk),
        .reset          (reset),
        .in_valid_i     (in_valid_s),
        .in_ready_o     (in_ready_s),
        .in_alg_i       (in_alg_s),
        .in_decrypt_i   (in_decrypt_s),
        .in_data_i      (in_data_s),
        .in_key_i       (in_key_s),
        .out_valid_o    (out_valid_s),
        .out_ready_i    (out_ready_s),
        .out_data_o     (out_data_s),
        .out_err_o      (out_err_s),
        .eng_input_o    (eng_input_s),
        .eng_key_o      (eng_key_s),
        .eng_sel_o      (eng_sel_s),
        .eng_round_sel_o(eng_round_sel_s),
        .eng_decrypt_o  (eng_decrypt_s),
        .eng_key_load_o (eng_key_load_s),
        .eng_data_load_o(eng_data_load_s),
        .eng_op_o       (eng_op_s),
        .eng_post_rdy_o (eng_post_rdy_s),
        .eng_output_i   (eng_output_s),
        .eng_ready_i    (eng_ready_s)
    );

    // 10-unit clock.
    always #5 clk = ~clk;

    // Engine output is a distinct value every cycle so a capture on the wrong cycle shows up.
    function automatic logic [63:0] eng_val(input int c);
        logic [31:0] w;
        w = 32'(c);
        return {w * 32'h9E37_79B9, w ^ 32'h5A5A_0F0F};
    endfunction

    function automatic logic [167:0] rand_key();
        logic [191:0] k;
        k = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        return k[167:0];
    endfunction

    task automatic check(input string tag, input logic [167:0] obs, input logic [167:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        eng_output_s = eng_val(cyc);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ":in_ready"}, 168'(in_ready_s), 168'd0);
        check({tag, ":out_valid"}, 168'(out_valid_s), 168'd0);
        check({tag, ":out_err"}, 168'(out_err_s), 168'd0);
        check({tag, ":out_data"}, 168'(out_data_s), 168'd0);
        check({tag, ":eng_input"}, 168'(eng_input_s), 168'd0);
        check({tag, ":eng_key"}, eng_key_s, 168'd0);
        check({tag, ":eng_sel"}, 168'(eng_sel_s), 168'd0);
        check({tag, ":round_sel"}, 168'(eng_round_sel_s), 168'd0);
        check({tag, ":eng_ctl"}, 168'({eng_decrypt_s, eng_key_load_s, eng_data_load_s,
                                       eng_op_s, eng_post_rdy_s}), 168'd0);
    endtask

    // One command from handshake to result acceptance. ready_at = WAIT cycle index
    // (0 = first WAIT cycle) at which the HIGHT core reports done; negative means never.
    task automatic do_cmd(input logic [1:0] alg, input logic dec, input logic [63:0] data,
                          input logic [167:0] key, input int ready_at, input int hold);
        int        lat, wait_end, c0, rs;
        logic      timeout, exp_err, exp_load, exp_op;
        logic [63:0] exp_data;

        timeout = (ready_at < 0) || (ready_at >= HIGHT_TO);
        case (alg)
            2'd0: lat = 1 + 1 + DES_N + 1;
            2'd1: lat = 1 + 1 + PRESENT_N + 1;
            2'd2: lat = timeout ? (1 + HIGHT_TO + 1) : (3 + ready_at + 1);
            default: lat = 1;
        endcase
        wait_end = timeout ? (1 + HIGHT_TO) : (2 + ready_at);
        exp_err  = (alg == 2'd3) || ((alg == 2'd2) && timeout);
        c0       = cyc;
        exp_data = exp_err ? 64'd0 : eng_val(c0 + lat - 1);

        check("hs_in_ready", 168'(in_ready_s), 168'd1);
        in_valid_s   = 1'b1;
        in_alg_s     = alg;
        in_decrypt_s = dec;
        in_data_s    = data;
        in_key_s     = key;
        tick();
        in_valid_s   = 1'b0;
        in_alg_s     = 2'($urandom_range(0, 3));
        in_decrypt_s = ~dec;
        in_data_s    = {$urandom(), $urandom()};
        in_key_s     = rand_key();

        for (int n = 1; n <= lat; n++) begin
            if (n > 1) tick();
            eng_ready_s = (alg == 2'd2) && !timeout && (n == 2 + ready_at);
            exp_load = (alg != 2'd3) && (n == 1);
            exp_op   = (alg == 2'd2) && (n >= 2) && (n <= wait_end);
            rs = 0;
            if ((alg == 2'd0) && (n >= 2) && (n <= 1 + DES_N)) rs = (n - 2 > 15) ? 15 : n - 2;
            check("out_valid", 168'(out_valid_s), 168'(n == lat));
            check("in_ready_busy", 168'(in_ready_s), 168'd0);
            check("key_load", 168'(eng_key_load_s), 168'(exp_load));
            check("data_load", 168'(eng_data_load_s), 168'(exp_load));
            check("eng_op", 168'(eng_op_s), 168'(exp_op));
            check("post_rdy", 168'(eng_post_rdy_s), 168'(exp_op));
            check("round_sel", 168'(eng_round_sel_s), 168'(rs));
            check("eng_sel", 168'(eng_sel_s), 168'(alg));
            check("eng_decrypt", 168'(eng_decrypt_s), 168'(dec));
            check("eng_input", 168'(eng_input_s), 168'(data));
            check("eng_key", eng_key_s, key);
        end
        eng_ready_s = 1'b0;
        check("out_data", 168'(out_data_s), 168'(exp_data));
        check("out_err", 168'(out_err_s), 168'(exp_err));

        for (int h = 0; h < hold; h++) begin
            tick();
            check("hold_valid", 168'(out_valid_s), 168'd1);
            check("hold_data", 168'(out_data_s), 168'(exp_data));
            check("hold_err", 168'(out_err_s), 168'(exp_err));
            check("hold_in_ready", 168'(in_ready_s), 168'd0);
        end
        out_ready_s = 1'b1;
        tick();
        out_ready_s = 1'b0;
        check("post_out_valid", 168'(out_valid_s), 168'd0);
        check("post_in_ready", 168'(in_ready_s), 168'd1);
    endtask

    initial begin
        logic [1:0] r_alg;
        int         r_ready;

        reset        = 1'b1;
        in_valid_s   = 1'b0;
        in_alg_s     = 2'd0;
        in_decrypt_s = 1'b0;
        in_data_s    = 64'd0;
        in_key_s     = 168'd0;
        out_ready_s  = 1'b0;
        eng_output_s = 64'd0;
        eng_ready_s  = 1'b0;

        tick();
        tick();
        check_all_zero("reset");
        reset = 1'b0;
        #1;
        check("rel_in_ready", 168'(in_ready_s), 168'd1);
        check("rel_out_valid", 168'(out_valid_s), 168'd0);

        do_cmd(2'd0, 1'b0, 64'h0123_4567_89AB_CDEF, rand_key(), -1, 2);
        do_cmd(2'd2, 1'b0, {$urandom(), $urandom()}, rand_key(), 10, 5);
        do_cmd(2'd2, 1'b1, {$urandom(), $urandom()}, rand_key(), -1, 1);
        do_cmd(2'd3, 1'b0, {$urandom(), $urandom()}, rand_key(), -1, 0);
        do_cmd(2'd2, 1'b0, {$urandom(), $urandom()}, rand_key(), 63, 0);
        do_cmd(2'd1, 1'b1, {$urandom(), $urandom()}, rand_key(), -1, 0);
        tick();

        // Abort a DES command in RUN with cnt = 7, then run a PRESENT command.
        in_valid_s = 1'b1;
        in_alg_s   = 2'd0;
        in_data_s  = {$urandom(), $urandom()};
        in_key_s   = rand_key();
        tick();
        in_valid_s = 1'b0;
        for (int n = 2; n <= 9; n++) tick();
        check("abort_round_sel", 168'(eng_round_sel_s), 168'd7);
        reset = 1'b1;
        #1;
        check_all_zero("abort_async");
        tick();
        check_all_zero("abort_held");
        reset = 1'b0;
        #1;
        check("abort_rel_in_ready", 168'(in_ready_s), 168'd1);
        do_cmd(2'd1, 1'b0, {$urandom(), $urandom()}, rand_key(), -1, 0);

        for (int i = 0; i < 14; i++) begin
            r_alg   = 2'($urandom_range(0, 3));
            r_ready = $urandom_range(0, 80);
            if (r_ready > 70) r_ready = -1;
            do_cmd(r_alg, 1'($urandom_range(0, 1)), {$urandom(), $urandom()}, rand_key(),
                   r_ready, $urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1) tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
